// File: rtl/traffic_gen_mp.sv
// Multi-packet wormhole traffic generator: emits head/body/tail packets on a
// valid/ready flit stream with programmable length, destination and gap.
module traffic_gen_mp #(
    parameter int FLIT_W   = 34,
    parameter int ADDR_W   = 8,
    parameter int MAX_BODY = 8,
    parameter int SEQ_W    = 16,
    parameter int GAP_W    = 8,
    localparam int BW      = $clog2(MAX_BODY + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [SEQ_W-1:0]  i_num_pkts,
    input  logic [BW-1:0]     i_body_len,
    input  logic [ADDR_W-1:0] i_dest,
    input  logic [GAP_W-1:0]  i_gap,
    output logic [FLIT_W-1:0] o_flit,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [SEQ_W-1:0]  o_pkts_sent,
    output logic [31:0]       o_flits_sent
);
    localparam int PAY_W = FLIT_W - 3;

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL, S_GAP, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [SEQ_W-1:0]   num_pkts_q;
    logic [BW-1:0]      body_len_q;
    logic [ADDR_W-1:0]  dest_q;
    logic [GAP_W-1:0]   gap_q;
    logic [SEQ_W-1:0]   seq;
    logic [SEQ_W-1:0]   pkts_sent;
    logic [31:0]        flits_sent;
    logic [BW-1:0]      idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic               stop_flag;

    logic               start_ok, xfer, stop_eff, last_pkt, body_last;
    logic [BW-1:0]      body_clamp;
    logic [1:0]         flit_type;
    logic [ADDR_W-1:0]  field;

    assign start_ok   = i_start && (state == S_IDLE || state == S_DONE);
    assign xfer       = o_valid && i_ready;
    // A stop raised in the same cycle as the deciding tail/gap cycle still counts.
    assign stop_eff   = stop_flag || i_stop;
    assign last_pkt   = (num_pkts_q != '0) && ((pkts_sent + SEQ_W'(1)) == num_pkts_q);
    assign body_last  = (idx == body_len_q - BW'(1));
    assign body_clamp = (i_body_len > BW'(MAX_BODY)) ? BW'(MAX_BODY) : i_body_len;

    assign o_valid      = (state == S_HEAD) || (state == S_BODY) || (state == S_TAIL);
    assign o_busy       = o_valid || (state == S_GAP);
    assign o_done       = (state == S_DONE);
    assign o_pkts_sent  = pkts_sent;
    assign o_flits_sent = flits_sent;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (i_start) state_nxt = S_HEAD;
            S_HEAD: if (xfer) state_nxt = (body_len_q == '0) ? S_TAIL : S_BODY;
            S_BODY: if (xfer && body_last) state_nxt = S_TAIL;
            S_TAIL: begin
                if (xfer) begin
                    if (stop_eff || last_pkt) state_nxt = S_DONE;
                    else if (gap_q == '0)     state_nxt = S_HEAD;
                    else                      state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (stop_eff)                   state_nxt = S_DONE;
                else if (gap_cnt == GAP_W'(1))  state_nxt = S_HEAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Flit is a pure function of registered state, so it cannot move during a stall.
    always_comb begin
        flit_type = 2'b00;
        field     = '0;
        case (state)
            S_HEAD: begin flit_type = 2'b01; field = dest_q; end
            S_BODY: begin flit_type = 2'b10; field = ADDR_W'(idx); end
            S_TAIL: begin flit_type = 2'b11; field = ADDR_W'(body_len_q) + ADDR_W'(2); end
            default: ;
        endcase
        o_flit = o_valid ? {1'b1, flit_type, PAY_W'({seq, field})} : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            seq        <= '0;
            pkts_sent  <= '0;
            flits_sent <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            stop_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                seq        <= '0;
                pkts_sent  <= '0;
                flits_sent <= '0;
                idx        <= '0;
                gap_cnt    <= '0;
                stop_flag  <= 1'b0;
            end else begin
                if (o_busy && i_stop) stop_flag <= 1'b1;
                if (xfer) flits_sent <= flits_sent + 32'd1;
                case (state)
                    S_HEAD: if (xfer) idx <= '0;
                    S_BODY: if (xfer) idx <= idx + BW'(1);
                    S_TAIL: begin
                        if (xfer) begin
                            pkts_sent <= pkts_sent + SEQ_W'(1);
                            seq       <= seq + SEQ_W'(1);
                            gap_cnt   <= gap_q;
                        end
                    end
                    S_GAP:   gap_cnt <= gap_cnt - GAP_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Run configuration is captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            num_pkts_q <= i_num_pkts;
            body_len_q <= body_clamp;
            dest_q     <= i_dest;
            gap_q      <= i_gap;
        end
    end
endmodule

// File: tb/tb_traffic_gen_mp.sv
// Self-checking bench for traffic_gen_mp: directed and randomized runs compared
// against a packet-level expected-flit queue.
module tb_traffic_gen_mp;
    localparam int FLIT_W = 34;
    localparam int LIMIT  = 3000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0, i_stop = 1'b0, i_ready = 1'b0;
    logic [15:0] i_num_pkts = '0;
    logic [3:0]  i_body_len = '0;
    logic [7:0]  i_dest = '0;
    logic [7:0]  i_gap = '0;
    logic [FLIT_W-1:0] o_flit;
    logic        o_valid, o_busy, o_done;
    logic [15:0] o_pkts_sent;
    logic [31:0] o_flits_sent;

    int checks = 0;
    int errors = 0;
    logic [FLIT_W-1:0] exp_q[$];
    int exp_total;

    traffic_gen_mp dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_stop(i_stop),
        .i_num_pkts(i_num_pkts), .i_body_len(i_body_len), .i_dest(i_dest),
        .i_gap(i_gap), .o_flit(o_flit), .o_valid(o_valid), .i_ready(i_ready),
        .o_busy(o_busy), .o_done(o_done), .o_pkts_sent(o_pkts_sent),
        .o_flits_sent(o_flits_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flit = valid bit, 2-bit type, payload = seq * 2^8 + field (zero-extended).
    function automatic logic [FLIT_W-1:0] mk(input int ty, input int sq, input int fld);
        logic [30:0] pay;
        pay = 31'(sq * 256 + fld);
        return {1'b1, 2'(ty), pay};
    endfunction

    task automatic build_exp(input int n, input int b, input int d);
        int bl;
        bl = (b > 8) ? 8 : b;
        exp_q.delete();
        for (int p = 0; p < n; p++) begin
            exp_q.push_back(mk(1, p, d));
            for (int i = 0; i < bl; i++) exp_q.push_back(mk(2, p, i));
            exp_q.push_back(mk(3, p, bl + 2));
        end
        exp_total = exp_q.size();
    endtask

    task automatic start_run(input int n, input int b, input int d, input int g,
                             input bit with_stop, input int model_pkts);
        i_num_pkts = 16'(n); i_body_len = 4'(b); i_dest = 8'(d); i_gap = 8'(g);
        i_start = 1'b1; i_stop = with_stop; i_ready = 1'b0;
        step();
        i_start = 1'b0; i_stop = 1'b0;
        build_exp(model_pkts, b, d);
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic run_check(input string tag, input int exp_pkts, input int exp_gap,
                             input int rmode, input int stop_seq, input bit poke_start);
        int cyc = 0;
        logic [FLIT_W-1:0] prev = '0;
        logic [FLIT_W-1:0] e;
        bit prev_stall = 1'b0;
        bit in_gap = 1'b0;
        int gap_cnt = 0;
        while (!o_done && cyc < LIMIT) begin
            case (rmode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            i_stop = (stop_seq >= 0) && o_valid && (o_flit[32:31] == 2'b10)
                     && (o_flit[23:8] == stop_seq[15:0]);
            if (poke_start && cyc == 2) begin
                i_start = 1'b1; i_dest = 8'h77; i_num_pkts = 16'd9; i_body_len = 4'd1; i_gap = 8'd5;
            end else begin
                i_start = 1'b0;
            end
            chk({tag, ":busy"}, o_busy, 1);
            if (prev_stall) chk({tag, ":stable"}, o_flit, prev);
            if (o_valid) begin
                if (in_gap && exp_gap >= 0) chk({tag, ":gap"}, gap_cnt, exp_gap);
                in_gap = 1'b0;
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        chk({tag, ":extra_flit"}, o_flit, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({tag, ":flit"}, o_flit, e);
                    end
                    if (o_flit[32:31] == 2'b11) begin
                        in_gap = 1'b1;
                        gap_cnt = 0;
                    end
                end
            end else if (in_gap) begin
                gap_cnt++;
            end
            prev = o_flit;
            prev_stall = o_valid && !i_ready;
            step();
            cyc++;
        end
        i_start = 1'b0; i_stop = 1'b0;
        chk({tag, ":timeout"}, cyc >= LIMIT, 0);
        chk({tag, ":done"}, o_done, 1);
        chk({tag, ":busy_end"}, o_busy, 0);
        chk({tag, ":valid_end"}, o_valid, 0);
        chk({tag, ":left"}, exp_q.size(), 0);
        chk({tag, ":pkts"}, o_pkts_sent, exp_pkts);
        chk({tag, ":flits"}, o_flits_sent, exp_total);
    endtask

    initial begin
        int n, b, d, g;
        // Reset state
        #2;
        chk("rst:flit", o_flit, 0);
        chk("rst:valid", o_valid, 0);
        chk("rst:busy", o_busy, 0);
        chk("rst:done", o_done, 0);
        chk("rst:pkts", o_pkts_sent, 0);
        chk("rst:flits", o_flits_sent, 0);
        step();
        reset_n = 1'b1;
        step();
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        chk("idle_stop:busy", o_busy, 0);

        // Basic run, back-to-back packets
        start_run(2, 2, 8'h05, 0, 1'b0, 2);
        run_check("basic", 2, 0, 0, -1, 1'b0);

        // Backpressure with an ignored mid-run start
        start_run(2, 2, 8'h05, 0, 1'b0, 2);
        run_check("bp", 2, 0, 1, -1, 1'b1);

        // Zero body, gap 3; start+stop together must still run to completion
        start_run(3, 0, 8'h3C, 3, 1'b1, 3);
        run_check("gap", 3, 3, 0, -1, 1'b0);

        // Body length clamp
        start_run(1, 15, 8'h42, 0, 1'b0, 1);
        run_check("clamp", 1, 0, 2, -1, 1'b0);

        // Continuous run stopped during body of seq 4
        start_run(0, 1, 8'h09, 0, 1'b0, 5);
        run_check("stop", 5, 0, 0, 4, 1'b0);

        // Randomized configurations under random backpressure
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 4);
            b = $urandom_range(0, 15);
            d = $urandom_range(0, 255);
            g = $urandom_range(0, 3);
            start_run(n, b, d, g, 1'b0, n);
            run_check("rand", n, g, 2, -1, 1'b0);
        end

        // Asynchronous reset mid-body, then restart
        start_run(0, 3, 8'h11, 0, 1'b0, 0);
        i_ready = 1'b1;
        for (int k = 0; k < 20 && !(o_valid && o_flit[32:31] == 2'b10); k++) step();
        chk("arst:reach_body", o_flit[32:31], 2);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst:flit", o_flit, 0);
        chk("arst:valid", o_valid, 0);
        chk("arst:busy", o_busy, 0);
        chk("arst:flits", o_flits_sent, 0);
        chk("arst:pkts", o_pkts_sent, 0);
        step();
        reset_n = 1'b1;
        step();
        start_run(1, 0, 8'hA3, 0, 1'b0, 1);
        chk("restart:head", o_flit, mk(1, 0, 8'hA3));
        run_check("restart", 1, 0, 0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_gen_mp.md
Name: traffic_gen_mp

Overview:
- Parametrised multi-packet traffic generator. It is the stimulus source at a router input port in NoC test harnesses.
- It emits a programmable number of wormhole packets (head / N body / tail) to a configurable destination, with a programmable inter-packet gap.
- Output is a valid/ready flit stream with no internal FIFO. Flits are generated on the fly and held stable under backpressure.
- It keeps per-run sequence numbers and packet/flit counters for scoreboarding.

Parameters:
- FLIT_W, 34, total flit width; must satisfy FLIT_W-3 >= SEQ_W+ADDR_W.
- ADDR_W, 8, destination address width.
- MAX_BODY, 8, maximum body flits per packet (>=1).
- SEQ_W, 16, sequence-number and packet-counter width.
- GAP_W, 8, inter-packet gap counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; latches config and starts a run (ignored unless IDLE or DONE)
- i_stop  in  1  request graceful stop (finish current packet, then DONE)
- i_num_pkts  in  SEQ_W  packets per run; 0 = continuous until i_stop
- i_body_len  in  $clog2(MAX_BODY+1)  body flits per packet; values >MAX_BODY clamp to MAX_BODY
- i_dest  in  ADDR_W  destination address placed in head flit
- i_gap  in  GAP_W  idle cycles between tail handshake and next head
- o_flit  out  FLIT_W  flit: [FLIT_W-1]=valid, [FLIT_W-2:FLIT_W-3]=type (00 none, 01 head, 10 body, 11 tail), [FLIT_W-4:0]=payload
- o_valid  out  1  flit valid
- i_ready  in  1  downstream accepts flit this cycle
- o_busy  out  1  run in progress (HEAD/BODY/TAIL/GAP)
- o_done  out  1  run complete; sticky until next accepted i_start
- o_pkts_sent  out  SEQ_W  tails accepted this run
- o_flits_sent  out  32  flits accepted this run

Behaviour:
- Reset values:
  - state IDLE; o_flit=0, o_valid=0, o_busy=0, o_done=0.
  - counters=0, seq=0, stop flag=0.
- Handshake:
  - A transfer occurs when o_valid&&i_ready.
  - While o_valid=1 and i_ready=0, o_flit is held bit-stable.
  - o_valid never drops without a transfer, except on reset.
- Payload encoding (zero-extended to FLIT_W-3):
  - head = {seq, i_dest latched}
  - body = {seq, body index starting at 0}
  - tail = {seq, total flits in packet = body_len+2}
- Config latch: i_start in IDLE/DONE latches i_num_pkts, clamped body_len, i_dest and i_gap. It also clears o_done, the counters, seq and the stop flag, then moves to HEAD next cycle.
- Config changes mid-run are ignored.
- States:
  - IDLE: o_valid=0. i_start -> HEAD.
  - HEAD: o_valid=1. On transfer: body_len=0 -> TAIL, else -> BODY.
  - BODY: o_valid=1. On transfer: index++. When index reaches body_len-1 at transfer -> TAIL.
  - TAIL: o_valid=1. On transfer: pkts_sent++, seq++. Then:
    - stop flag set or pkts_sent+1==num_pkts (num_pkts!=0) -> DONE
    - else i_gap==0 -> HEAD (back-to-back; head valid the cycle after tail)
    - else -> GAP
  - GAP: o_valid=0. Counts i_gap cycles, then -> HEAD.
    - If the stop flag is set while in GAP -> DONE immediately; no partial packet is emitted.
  - DONE: o_done=1, o_valid=0. i_start -> HEAD (new run).
- o_busy = state in {HEAD, BODY, TAIL, GAP}.
- i_stop:
  - Sets the sticky stop flag when asserted in any busy state.
  - A packet is never truncated; the stop takes effect at the next tail transfer or in GAP.
  - i_stop in IDLE/DONE has no effect.
- i_start while busy: ignored.
- i_start and i_stop in the same cycle in IDLE: the run starts and the stop flag is cleared (start wins).
- Wrap-around:
  - seq and o_pkts_sent wrap modulo 2^SEQ_W in continuous mode.
  - o_flits_sent wraps modulo 2^32.
- Asynchronous reset mid-packet: immediate return to reset values; no tail is emitted.
- Throughput with i_ready=1 and gap 0: one flit per cycle sustained across packet boundaries.

Test Plan:
- Basic run: num_pkts=2, body_len=2, dest=0x05, gap=0, i_ready=1.
  - Expect 8 consecutive flits: H(seq0,dest5) B0 B1 T(4), then H(seq1) B0 B1 T(4).
  - Then o_done=1, o_pkts_sent=2, o_flits_sent=8.
- Backpressure: same config, i_ready toggled 1,0,0,1 pattern.
  - o_flit stable during stalls.
  - Identical flit sequence; o_flits_sent=8.
- Gap and zero body: num_pkts=3, body_len=0, gap=3.
  - Each packet is H then T.
  - Exactly 3 cycles of o_valid=0 between a tail transfer and the next head.
  - o_flits_sent=6.
- Clamp: body_len=15 with MAX_BODY=8.
  - 8 body flits, indices 0..7; tail payload count=10.
- Continuous plus stop: num_pkts=0, body_len=1.
  - Assert i_stop during the BODY flit of packet 5 (seq4).
  - That packet's tail is still emitted; DONE follows with o_pkts_sent=5.
- Reset and restart: reset_n low mid-BODY.
  - All outputs return to 0 asynchronously.
  - After release, i_start with new dest=0xA3 produces a head with seq0 and dest 0xA3.
  - i_start pulsed while busy does not alter the run.
